cache_nway: RTL and testbench



---
 rtl/cache_nway.sv | 255 +++++++++++++++++++++++++
 tb/tb_cache_nway.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway.sv
// cache_nway: write-back, write-allocate N-way set-associative cache with
// 4-word (128-bit) lines and a three-state miss controller.
// Ports:
//   clk, proc_reset        - clock, asynchronous active-high reset
//   proc_read/proc_write   - processor request (write wins if both set)
//   proc_addr/proc_wdata   - word address, write data
//   proc_stall/proc_rdata  - combinational stall and read data
//   mem_read/mem_write     - registered block read / write-back request
//   mem_addr/mem_wdata     - registered block address and write-back line
//   mem_rdata/mem_ready    - fill data and one-cycle completion pulse
module cache_nway #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 4
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic          proc_stall,
  output logic [31:0]   proc_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  input  logic [127:0]  mem_rdata,
  output logic [127:0]  mem_wdata,
  input  logic          mem_ready
);

  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 28 - IW;
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned PW = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] dirty_q [WAYS];
  logic [TW-1:0]   tag_q   [WAYS][SETS];
  logic [127:0]    data_q  [WAYS][SETS];
  logic [PW-1:0]   plru_q  [SETS];

  // Miss context captured on leaving IDLE so the miss completes even if the
  // request drops or the address moves.
  logic [27:0]   addr_q;
  logic [WW-1:0] vict_q;

  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [27:0]   mem_addr_q, mem_addr_d;
  logic [127:0]  mem_wdata_q, mem_wdata_d;

  logic          req, wr;
  logic [1:0]    req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] miss_idx;
  logic [TW-1:0] miss_tag;

  assign req      = proc_read | proc_write;
  assign wr       = proc_write;
  assign req_off  = proc_addr[1:0];
  assign req_idx  = proc_addr[IW+1:2];
  assign req_tag  = proc_addr[29:IW+2];
  assign miss_idx = addr_q[IW-1:0];
  assign miss_tag = addr_q[27:IW];

  // Tag lookup across all ways of the addressed set.
  logic          hit;
  logic [WW-1:0] hit_way;
  logic [127:0]  hit_line;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_way  = WW'(w);
        hit_line = data_q[w][req_idx];
      end
    end
  end

  // Pseudo-LRU decode and update. Bits point at the way to evict next;
  // for the 4-way tree bit0 picks the half, bit1/bit2 the way within it.
  logic [2:0]    plru_cur;
  logic [2:0]    plru_nxt;
  logic [1:0]    hit_way2;
  logic [WW-1:0] plru_way;

  assign plru_cur = 3'(plru_q[req_idx]);
  assign hit_way2 = 2'(hit_way);

  always_comb begin
    plru_way = '0;
    plru_nxt = plru_cur;
    if (WAYS == 2) begin
      plru_way    = WW'(plru_cur[0]);
      plru_nxt[0] = ~hit_way2[0];
    end else if (WAYS == 4) begin
      plru_way    = plru_cur[0] ? WW'(plru_cur[2] ? 2'd3 : 2'd2)
                                : WW'(plru_cur[1] ? 2'd1 : 2'd0);
      plru_nxt[0] = ~hit_way2[1];
      if (!hit_way2[1]) plru_nxt[1] = ~hit_way2[0];
      else              plru_nxt[2] = ~hit_way2[0];
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the PLRU way.
  logic          inv_found;
  logic [WW-1:0] vict_way;
  logic          vict_valid, vict_dirty;
  logic [TW-1:0] vict_tag;
  logic [127:0]  vict_line;

  always_comb begin
    inv_found = 1'b0;
    vict_way  = plru_way;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        vict_way  = WW'(w);
      end
    end
    vict_valid = 1'b0;
    vict_dirty = 1'b0;
    vict_tag   = '0;
    vict_line  = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (WW'(w) == vict_way) begin
        vict_valid = valid_q[w][req_idx];
        vict_dirty = dirty_q[w][req_idx];
        vict_tag   = tag_q[w][req_idx];
        vict_line  = data_q[w][req_idx];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) state_d = (vict_valid && vict_dirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: if (mem_ready) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: memory-side values are computed for the next state and
  // registered; processor-side stall/data are combinational.
  always_comb begin
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    proc_stall  = 1'b0;
    proc_rdata  = '0;
    case (state_d)
      WRITEBACK: mem_write_d = 1'b1;
      ALLOCATE:  mem_read_d  = 1'b1;
      default:   ;
    endcase
    if (state_q == IDLE && state_d == WRITEBACK) begin
      mem_addr_d  = {vict_tag, req_idx};
      mem_wdata_d = vict_line;
    end else if (state_q == IDLE && state_d == ALLOCATE) begin
      mem_addr_d = proc_addr[29:2];
    end else if (state_q == WRITEBACK && state_d == ALLOCATE) begin
      mem_addr_d = addr_q;
    end
    if (!proc_reset) begin
      proc_stall = (state_q != IDLE) || (req && !hit);
      if (state_q == IDLE && proc_read && !proc_write && hit)
        proc_rdata = 32'(hit_line >> {req_off, 5'b0});
    end
  end

  // Control state: output registers, valid/dirty/PLRU, miss context.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_q      <= '0;
      vict_q      <= '0;
      for (int w = 0; w < int'(WAYS); w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == IDLE && req) begin
        if (hit) begin
          plru_q[req_idx] <= PW'(plru_nxt);
          if (wr) begin
            for (int w = 0; w < int'(WAYS); w++)
              if (WW'(w) == hit_way) dirty_q[w][req_idx] <= 1'b1;
          end
        end else begin
          addr_q <= proc_addr[29:2];
          vict_q <= vict_way;
        end
      end
      if (state_q == ALLOCATE && mem_ready) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          if (WW'(w) == vict_q) begin
            valid_q[w][miss_idx] <= 1'b1;
            dirty_q[w][miss_idx] <= 1'b0;
          end
        end
      end
    end
  end

  // Data and tag arrays: contents need no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req && hit && wr) begin
      for (int w = 0; w < int'(WAYS); w++)
        if (WW'(w) == hit_way) data_q[w][req_idx][{req_off, 5'b0} +: 32] <= proc_wdata;
    end
    if (state_q == ALLOCATE && mem_ready) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (WW'(w) == vict_q) begin
          data_q[w][miss_idx] <= mem_rdata;
          tag_q[w][miss_idx]  <= miss_tag;
        end
      end
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a 2-way/4-set instance and a direct-mapped
// instance share the request and memory-response inputs; sel picks which
// instance's outputs are checked.
module tb_cache_nway;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset, proc_read, proc_write, mem_ready;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [127:0] mem_rdata;

  logic         a_stall, a_mrd, a_mwr, b_stall, b_mrd, b_mwr;
  logic [31:0]  a_rdata, b_rdata;
  logic [27:0]  a_maddr, b_maddr;
  logic [127:0] a_mwdata, b_mwdata;

  logic         sel;
  logic         o_stall, o_mrd, o_mwr;
  logic [31:0]  o_rdata;
  logic [27:0]  o_maddr;
  logic [127:0] o_mwdata;

  assign o_stall  = sel ? b_stall  : a_stall;
  assign o_mrd    = sel ? b_mrd    : a_mrd;
  assign o_mwr    = sel ? b_mwr    : a_mwr;
  assign o_rdata  = sel ? b_rdata  : a_rdata;
  assign o_maddr  = sel ? b_maddr  : a_maddr;
  assign o_mwdata = sel ? b_mwdata : a_mwdata;

  cache_nway #(.WAYS(2), .SETS(4)) u_dut2 (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(a_stall), .proc_rdata(a_rdata),
    .mem_read(a_mrd), .mem_write(a_mwr), .mem_addr(a_maddr), .mem_rdata(mem_rdata),
    .mem_wdata(a_mwdata), .mem_ready(mem_ready));

  cache_nway #(.WAYS(1), .SETS(4)) u_dut1 (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(b_stall), .proc_rdata(b_rdata),
    .mem_read(b_mrd), .mem_write(b_mwr), .mem_addr(b_maddr), .mem_rdata(mem_rdata),
    .mem_wdata(b_mwdata), .mem_ready(mem_ready));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Move to just after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    #1;
  endtask

  // One-cycle mem_ready pulse spanning the next rising edge.
  task automatic respond(input logic [127:0] d);
    mem_ready = 1'b1;
    mem_rdata = d;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
  endtask

  task automatic do_reset();
    step();
    proc_reset = 1'b1;
    set_req(1'b0, 1'b0, 30'h0, 32'h0);
    step();
    step();
    proc_reset = 1'b0;
    #1;
  endtask

  initial begin
    sel        = 1'b0;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;

    // Reset state, with a request held to show stall is forced low.
    step();
    set_req(1'b1, 1'b0, 30'h5, 32'h0);
    step();
    chk("rst_stall", o_stall, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_mrd",   o_mrd,   0);
    chk("rst_mwr",   o_mwr,   0);
    chk("rst_maddr", o_maddr, 0);
    chk("rst_mwdata", o_mwdata, 0);
    set_req(1'b0, 1'b0, 30'h0, 32'h0);
    proc_reset = 1'b0;
    step();
    chk("idle_stall", o_stall, 0);
    chk("idle_rdata", o_rdata, 0);

    // Cold read miss and fill.
    step();
    set_req(1'b1, 1'b0, 30'h5, 32'h0);
    chk("cold_stall", o_stall, 1);
    chk("cold_mrd0",  o_mrd,   0);
    step();
    chk("cold_mrd",   o_mrd,   1);
    chk("cold_maddr", o_maddr, 28'h1);
    chk("cold_stall2", o_stall, 1);
    respond(128'h0000_3333_0000_2222_0000_1111_0000_0000);
    chk("cold_hit_stall", o_stall, 0);
    chk("cold_rdata", o_rdata, 32'h1111);
    chk("cold_mrd_off", o_mrd, 0);

    // Write hit, then read back.
    set_req(1'b0, 1'b1, 30'h5, 32'hDEADBEEF);
    chk("wr_stall", o_stall, 0);
    step();
    set_req(1'b1, 1'b0, 30'h5, 32'h0);
    chk("rb_stall", o_stall, 0);
    chk("rb_rdata", o_rdata, 32'hDEADBEEF);
    chk("rb_mrd", o_mrd, 0);
    chk("rb_mwr", o_mwr, 0);
    // Read+write together acts as a write.
    step();
    set_req(1'b1, 1'b1, 30'h6, 32'hCAFEF00D);
    chk("rw_stall", o_stall, 0);
    step();
    set_req(1'b1, 1'b0, 30'h6, 32'h0);
    chk("rw_rdata", o_rdata, 32'hCAFEF00D);

    // Second way fill, then dirty eviction of the line holding 30'h04.
    step();
    set_req(1'b1, 1'b0, 30'h14, 32'h0);
    chk("f14_stall", o_stall, 1);
    step();
    chk("f14_mrd", o_mrd, 1);
    chk("f14_maddr", o_maddr, 28'h5);
    respond(128'h0000_0017_0000_0016_0000_0015_0000_0014);
    chk("f14_rdata", o_rdata, 32'h14);
    step();
    set_req(1'b1, 1'b0, 30'h24, 32'h0);
    chk("ev_stall", o_stall, 1);
    step();
    chk("ev_mwr", o_mwr, 1);
    chk("ev_mrd", o_mrd, 0);
    chk("ev_maddr", o_maddr, 28'h1);
    chk("ev_mwdata_w1", o_mwdata[63:32], 32'hDEADBEEF);
    chk("ev_mwdata", o_mwdata, 128'h0000_3333_CAFE_F00D_DEAD_BEEF_0000_0000);
    step();
    chk("ev_hold_mwr", o_mwr, 1);
    chk("ev_hold_stall", o_stall, 1);
    respond(128'h0);
    chk("ev_alloc_mrd", o_mrd, 1);
    chk("ev_alloc_mwr", o_mwr, 0);
    chk("ev_alloc_maddr", o_maddr, 28'h9);
    chk("ev_alloc_stall", o_stall, 1);
    respond(128'h0000_0027_0000_0026_0000_0025_0000_0024);
    chk("ev_rdata", o_rdata, 32'h24);
    chk("ev_stall_done", o_stall, 0);
    step();
    set_req(1'b1, 1'b0, 30'h15, 32'h0);
    chk("keep14_stall", o_stall, 0);
    chk("keep14_rdata", o_rdata, 32'h15);

    // Clean eviction; the request for 30'h24 drops mid-miss.
    do_reset();
    step();
    set_req(1'b1, 1'b0, 30'h04, 32'h0);
    step();
    respond(128'h0000_0000_0000_0000_0000_0000_0000_0004);
    step();
    set_req(1'b1, 1'b0, 30'h14, 32'h0);
    step();
    respond(128'h0000_0000_0000_0000_0000_0000_0000_0014);
    step();
    set_req(1'b1, 1'b0, 30'h24, 32'h0);
    chk("cl_stall", o_stall, 1);
    step();
    set_req(1'b0, 1'b0, 30'h0, 32'h0);
    chk("cl_mrd", o_mrd, 1);
    chk("cl_mwr", o_mwr, 0);
    chk("cl_maddr", o_maddr, 28'h9);
    chk("cl_drop_stall", o_stall, 1);
    respond(128'h0000_0000_0000_0000_0000_0000_0000_0024);
    chk("cl_idle_stall", o_stall, 0);
    chk("cl_idle_mrd", o_mrd, 0);
    chk("cl_idle_rdata", o_rdata, 0);
    step();
    set_req(1'b1, 1'b0, 30'h24, 32'h0);
    chk("cl_rehit_stall", o_stall, 0);
    chk("cl_rehit_rdata", o_rdata, 32'h24);

    // Reset in the middle of an allocate.
    do_reset();
    step();
    set_req(1'b1, 1'b0, 30'h04, 32'h0);
    step();
    chk("ra_mrd", o_mrd, 1);
    #1;
    proc_reset = 1'b1;
    #1;
    chk("ra_mrd_async", o_mrd, 0);
    chk("ra_stall", o_stall, 0);
    set_req(1'b0, 1'b0, 30'h0, 32'h0);
    step();
    proc_reset = 1'b0;
    respond(128'h0000_0000_0000_0000_0000_0000_0000_00EE);
    chk("ra_late_ready_mrd", o_mrd, 0);
    set_req(1'b1, 1'b0, 30'h04, 32'h0);
    chk("ra_remiss_stall", o_stall, 1);
    step();
    chk("ra_remiss_mrd", o_mrd, 1);
    chk("ra_remiss_maddr", o_maddr, 28'h1);
    respond(128'h0000_0000_0000_0000_0000_0000_0000_0004);
    chk("ra_rdata", o_rdata, 32'h4);

    // Direct-mapped instance: alternating conflicting reads always miss.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [29:0] a;
      logic [27:0] ba;
      a  = (i % 2 == 0) ? 30'h04 : 30'h14;
      ba = (i % 2 == 0) ? 28'h1 : 28'h5;
      step();
      set_req(1'b1, 1'b0, a, 32'h0);
      chk($sformatf("dm%0d_stall", i), o_stall, 1);
      step();
      chk($sformatf("dm%0d_mrd", i), o_mrd, 1);
      chk($sformatf("dm%0d_mwr", i), o_mwr, 0);
      chk($sformatf("dm%0d_maddr", i), o_maddr, ba);
      respond({96'h0, 2'b0, a});
      chk($sformatf("dm%0d_rdata", i), o_rdata, {2'b0, a});
      set_req(1'b0, 1'b0, 30'h0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
